// File: rtl/dino_jump_ctrl_if.sv
// Control/status bundle between the game datapath and the dino motion controller.
// The master drives frame/button inputs; the controller (slave) drives sprite motion state.
interface dino_jump_ctrl_if #(
   parameter int unsigned Y_W = 10
);
   logic           frame_tick;
   logic           enable;
   logic           jump_btn;
   logic [Y_W-1:0] sprite_y;
   logic [9:0]     scroll_x;
   logic           airborne;
   logic           landed;
   logic [1:0]     state;
   logic [7:0]     jump_count;

   modport master (
      output frame_tick, enable, jump_btn,
      input  sprite_y, scroll_x, airborne, landed, state, jump_count
   );

   modport slave (
      input  frame_tick, enable, jump_btn,
      output sprite_y, scroll_x, airborne, landed, state, jump_count
   );
endinterface

// File: rtl/dino_jump_ctrl.sv
// Per-frame dino motion controller: jump state machine for sprite_y plus background scroll.
// Everything advances only on frames where the game is enabled; button edges are always latched.
module dino_jump_ctrl #(
   parameter int unsigned GROUND_Y     = 300,
   parameter int unsigned JUMP_VEL     = 12,
   parameter int unsigned GRAVITY      = 1,
   parameter int unsigned MAX_VEL      = 15,
   parameter int unsigned SCREEN_W     = 640,
   parameter int unsigned SCROLL_SPEED = 4,
   parameter int unsigned Y_W          = 10
) (
   input  logic             clk,
   input  logic             reset,
   dino_jump_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      StGround = 2'd0,
      StRise   = 2'd1,
      StFall   = 2'd2,
      StLand   = 2'd3
   } state_t;

   localparam logic [Y_W-1:0] GroundY = Y_W'(GROUND_Y);
   localparam logic [Y_W-1:0] JumpVel = Y_W'(JUMP_VEL);
   localparam logic [Y_W-1:0] Gravity = Y_W'(GRAVITY);
   localparam logic [Y_W-1:0] MaxVel  = Y_W'(MAX_VEL);

   state_t         state_q;
   logic [Y_W-1:0] sprite_q;
   logic [Y_W-1:0] vel_q;
   logic [9:0]     scroll_q;
   logic [7:0]     count_q;
   logic           jump_req_q;
   logic           landed_q;
   logic           airborne_q;
   logic           btn_s1, btn_s2, btn_s3;

   logic           tick;
   logic           btn_rise;
   logic [Y_W:0]   fall_sum;
   logic [Y_W:0]   vel_inc;
   logic [10:0]    scroll_sum;

   assign tick       = bus.frame_tick & bus.enable;
   assign btn_rise   = btn_s2 & ~btn_s3;
   // One extra bit so position + speed never wraps before the ground compare.
   assign fall_sum   = {1'b0, sprite_q} + {1'b0, vel_q};
   assign vel_inc    = {1'b0, vel_q} + {1'b0, Gravity};
   assign scroll_sum = {1'b0, scroll_q} + 11'(SCROLL_SPEED);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StGround;
         sprite_q   <= GroundY;
         vel_q      <= '0;
         scroll_q   <= '0;
         count_q    <= '0;
         jump_req_q <= 1'b0;
         landed_q   <= 1'b0;
         airborne_q <= 1'b0;
         btn_s1     <= 1'b0;
         btn_s2     <= 1'b0;
         btn_s3     <= 1'b0;
      end else begin
         btn_s1   <= bus.jump_btn;
         btn_s2   <= btn_s1;
         btn_s3   <= btn_s2;
         landed_q <= 1'b0;

         // A clear issued by a tick below overrides an edge arriving on the same clk.
         if (btn_rise) jump_req_q <= 1'b1;

         if (tick) begin
            if (scroll_sum >= 11'(SCREEN_W)) scroll_q <= 10'(scroll_sum - 11'(SCREEN_W));
            else                             scroll_q <= scroll_sum[9:0];

            unique case (state_q)
               StGround: begin
                  if (jump_req_q) begin
                     state_q    <= StRise;
                     airborne_q <= 1'b1;
                     vel_q      <= JumpVel;
                     jump_req_q <= 1'b0;
                     if (count_q != 8'hFF) count_q <= count_q + 8'd1;
                  end
               end
               StRise: begin
                  sprite_q   <= sprite_q - vel_q;
                  jump_req_q <= 1'b0;
                  if (vel_q > Gravity) begin
                     vel_q <= vel_q - Gravity;
                  end else begin
                     vel_q   <= '0;
                     state_q <= StFall;
                  end
               end
               StFall: begin
                  jump_req_q <= 1'b0;
                  if (fall_sum >= {1'b0, GroundY}) begin
                     sprite_q   <= GroundY;
                     vel_q      <= '0;
                     state_q    <= StLand;
                     landed_q   <= 1'b1;
                     airborne_q <= 1'b0;
                  end else begin
                     sprite_q <= fall_sum[Y_W-1:0];
                     vel_q    <= (vel_inc > {1'b0, MaxVel}) ? MaxVel : vel_inc[Y_W-1:0];
                  end
               end
               StLand: begin
                  state_q <= StGround;
               end
            endcase
         end
      end
   end

   assign bus.sprite_y   = sprite_q;
   assign bus.scroll_x   = scroll_q;
   assign bus.airborne   = airborne_q;
   assign bus.landed     = landed_q;
   assign bus.state      = state_q;
   assign bus.jump_count = count_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Bench for dino_jump_ctrl: directed trajectory scenarios plus randomized frames,
// every cycle compared against a frame-level behavioural model.
module tb_dino_jump_ctrl;

   localparam int GROUND_Y = 300;
   localparam int JUMP_VEL = 12;
   localparam int GRAVITY  = 1;
   localparam int MAX_VEL  = 15;
   localparam int SCREEN_W = 640;
   localparam int SPEED    = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dino_jump_ctrl_if #(.Y_W(10)) bus ();
   dino_jump_ctrl_if #(.Y_W(10)) bus7 ();

   dino_jump_ctrl #(
      .GROUND_Y(300), .JUMP_VEL(12), .GRAVITY(1), .MAX_VEL(15),
      .SCREEN_W(640), .SCROLL_SPEED(4), .Y_W(10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   dino_jump_ctrl #(
      .GROUND_Y(300), .JUMP_VEL(12), .GRAVITY(1), .MAX_VEL(15),
      .SCREEN_W(640), .SCROLL_SPEED(7), .Y_W(10)
   ) dut7 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus7)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model: 0 ground, 1 rise, 2 fall, 3 land.
   int m_state, m_y, m_vel, m_scroll, m_count, m_req, m_landed;
   int hist[3]; // button as sampled on the last three clocks, newest first

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_state = 0; m_y = GROUND_Y; m_vel = 0; m_scroll = 0;
      m_count = 0; m_req = 0; m_landed = 0;
      for (int i = 0; i < 3; i++) hist[i] = 0;
   endtask

   task automatic model_clock(input bit ft, input bit en, input bit btn);
      bit edge_seen;
      bit cleared;
      edge_seen = (hist[1] == 1) && (hist[2] == 0);
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = btn;
      m_landed = 0;
      cleared  = 0;
      if (ft && en) begin
         m_scroll = (m_scroll + SPEED) % SCREEN_W;
         case (m_state)
            0: if (m_req != 0) begin
                  m_state = 1; m_vel = JUMP_VEL; cleared = 1;
                  m_count = (m_count < 255) ? m_count + 1 : 255;
               end
            1: begin
                  m_y = m_y - m_vel; cleared = 1;
                  if (m_vel > GRAVITY) m_vel = m_vel - GRAVITY;
                  else begin m_vel = 0; m_state = 2; end
               end
            2: begin
                  cleared = 1;
                  if (m_y + m_vel >= GROUND_Y) begin
                     m_y = GROUND_Y; m_vel = 0; m_state = 3; m_landed = 1;
                  end else begin
                     m_y = m_y + m_vel;
                     m_vel = (m_vel + GRAVITY > MAX_VEL) ? MAX_VEL : m_vel + GRAVITY;
                  end
               end
            default: m_state = 0;
         endcase
      end
      if (cleared) m_req = 0;
      else if (edge_seen) m_req = 1;
   endtask

   task automatic compare_all(input string tag);
      check_eq({tag, ".sprite_y"},   int'(bus.sprite_y),   m_y);
      check_eq({tag, ".scroll_x"},   int'(bus.scroll_x),   m_scroll);
      check_eq({tag, ".state"},      int'(bus.state),      m_state);
      check_eq({tag, ".airborne"},   int'(bus.airborne),   (m_state == 1 || m_state == 2) ? 1 : 0);
      check_eq({tag, ".landed"},     int'(bus.landed),     m_landed);
      check_eq({tag, ".jump_count"}, int'(bus.jump_count), m_count);
   endtask

   // Entered and left at posedge+1.
   task automatic step(input bit ft, input bit en, input bit btn, input string tag);
      bus.frame_tick = ft;
      bus.enable     = en;
      bus.jump_btn   = btn;
      @(posedge clk);
      model_clock(ft, en, btn);
      #1;
      compare_all(tag);
   endtask

   task automatic apply_reset(input string tag);
      reset = 1'b1;
      #1;
      model_reset();
      compare_all({tag, ".async"});
      @(posedge clk);
      #1;
      reset = 1'b0;
      compare_all({tag, ".held"});
   endtask

   int rise_y;
   bit b;

   initial begin
      bus.frame_tick = 1'b0; bus.enable = 1'b1; bus.jump_btn = 1'b0;
      bus7.frame_tick = 1'b0; bus7.enable = 1'b1; bus7.jump_btn = 1'b0;
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      apply_reset("init");

      // Wider scroll step wraps 637 -> 4.
      bus7.frame_tick = 1'b1;
      for (int i = 0; i < 91; i++) step(0, 1, 0, "idle7");
      check_eq("scroll7.pre_wrap", int'(bus7.scroll_x), 637);
      step(0, 1, 0, "idle7");
      check_eq("scroll7.wrap", int'(bus7.scroll_x), 4);
      bus7.frame_tick = 1'b0;

      // Standing still for 200 frames.
      for (int i = 0; i < 200; i++) begin
         step(1, 1, 0, "ground");
         check_eq("ground.y", int'(bus.sprite_y), GROUND_Y);
      end
      check_eq("ground.scroll200", int'(bus.scroll_x), (4 * 200) % 640);

      // Press, wait out the synchronizer, then launch.
      for (int i = 0; i < 3; i++) step(0, 1, 1, "press");
      step(1, 1, 1, "launch");
      check_eq("launch.state", int'(bus.state), 1);
      check_eq("launch.count", int'(bus.jump_count), 1);
      check_eq("launch.y", int'(bus.sprite_y), GROUND_Y);

      rise_y = GROUND_Y;
      for (int k = 1; k <= 12; k++) begin
         rise_y = rise_y - (JUMP_VEL - (k - 1));
         step(1, 1, k[0], "rise");
         check_eq("rise.y", int'(bus.sprite_y), rise_y);
         if (k == 5) begin
            check_eq("rise.y250", int'(bus.sprite_y), 250);
            for (int f = 0; f < 50; f++) step(1, 0, f[1], "freeze");
            check_eq("freeze.y", int'(bus.sprite_y), 250);
            check_eq("freeze.state", int'(bus.state), 1);
         end
      end
      check_eq("peak.y", int'(bus.sprite_y), 222);
      check_eq("peak.state", int'(bus.state), 2);

      for (int k = 1; k <= 13; k++) begin
         step(1, 1, (k <= 9) ? k[0] : 1'b0, "fall");
         check_eq("fall.y", int'(bus.sprite_y), (k <= 12) ? 222 + k * (k - 1) / 2 : GROUND_Y);
         check_eq("fall.landed", int'(bus.landed), (k == 13) ? 1 : 0);
      end
      check_eq("land.state", int'(bus.state), 3);
      check_eq("land.count", int'(bus.jump_count), 1);
      step(0, 1, 0, "land_idle");
      check_eq("landed.pulse_cleared", int'(bus.landed), 0);

      // Press while in LAND is buffered for the first GROUND tick.
      for (int i = 0; i < 4; i++) step(0, 1, 1, "land_press");
      step(1, 1, 1, "land_exit");
      check_eq("land_exit.state", int'(bus.state), 0);
      step(1, 1, 0, "relaunch");
      check_eq("relaunch.state", int'(bus.state), 1);
      check_eq("relaunch.count", int'(bus.jump_count), 2);

      // Reset in the middle of a fall.
      for (int i = 0; i < 18; i++) step(1, 1, 0, "jump2");
      check_eq("jump2.falling", int'(bus.state), 2);
      apply_reset("midfall");
      check_eq("midfall.y", int'(bus.sprite_y), GROUND_Y);
      check_eq("midfall.count", int'(bus.jump_count), 0);

      // Saturate the jump counter.
      for (int j = 0; j < 300; j++) begin
         step(1, 1, 1, "sat");
         step(1, 1, 1, "sat");
         for (int i = 0; i < 32; i++) step(1, 1, 0, "sat");
      end
      check_eq("sat.count", int'(bus.jump_count), 255);

      // Random frames, enables, button levels and occasional resets.
      b = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 19) == 0) b = ~b;
         if ($urandom_range(0, 1499) == 0) apply_reset("rnd_rst");
         else step(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) != 0), b, "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
